// File: rtl/micro_pkg.sv
// Shared definitions for the microinstruction pipeline: default field widths
// and the NOP word that every stage loads on flush/reset or for a bubble.
package micro_pkg;

    localparam int ALU_W_DEF  = 4;
    localparam int SH_W_DEF   = 2;
    localparam int C_W_DEF    = 6;
    localparam int T_W_DEF    = 7;
    localparam int ADDR_W_DEF = 11;
    localparam int M_W_DEF    = 2;

    typedef struct packed {
        logic                  valid;
        logic [ALU_W_DEF-1:0]  alu;
        logic [SH_W_DEF-1:0]   sh;
        logic [C_W_DEF-1:0]    c;
        logic [T_W_DEF-1:0]    t;
        logic [ADDR_W_DEF-1:0] addr;
        logic [M_W_DEF-1:0]    m;
    } micro_word_t;

    localparam micro_word_t MICRO_NOP = '0;

endpackage

// File: rtl/micro_stage.sv
// One pipeline register stage: valid bit plus a flattened microinstruction word.
// Flush beats stall; a stage holding a bubble always stores zero fields.
module micro_stage
    import micro_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= MICRO_NOP.valid;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= MICRO_NOP.valid;
            r_data  <= '0;
        end else if (!stall) begin
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/micro_pipeline.sv
// DEPTH-stage microinstruction delay line with global stall/flush and a
// saturating count of unstalled cycles that present no valid output.
module micro_pipeline
    import micro_pkg::*;
#(
    parameter int ALU_W  = ALU_W_DEF,
    parameter int SH_W   = SH_W_DEF,
    parameter int C_W    = C_W_DEF,
    parameter int T_W    = T_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int M_W    = M_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ALU_W-1:0]  ALU_in,
    input  logic [SH_W-1:0]   SH_in,
    input  logic [C_W-1:0]    C_in,
    input  logic [T_W-1:0]    T_in,
    input  logic [ADDR_W-1:0] DATA_ADDR_in,
    input  logic [M_W-1:0]    M_in,
    output logic [ALU_W-1:0]  ALU_out,
    output logic [SH_W-1:0]   SH_out,
    output logic [C_W-1:0]    C_out,
    output logic [T_W-1:0]    T_out,
    output logic [ADDR_W-1:0] DATA_ADDR_out,
    output logic [M_W-1:0]    M_out,
    output logic              out_valid,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [15:0]       bubbles
);

    localparam int W = ALU_W + SH_W + C_W + T_W + ADDR_W + M_W;

    // Index 0 is the input side; index k is the output of stage k-1.
    logic [DEPTH:0]        w_vld_pipe;
    logic [DEPTH:0][W-1:0] w_data_pipe;
    logic [15:0]           r_bubbles;

    assign w_vld_pipe[0]  = in_valid;
    assign w_data_pipe[0] = {ALU_in, SH_in, C_in, T_in, DATA_ADDR_in, M_in};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        micro_stage #(.W(W)) u_stage (
            .clock   (clock),
            .reset   (reset),
            .stall   (stall),
            .flush   (flush),
            .i_valid (w_vld_pipe[k]),
            .i_data  (w_data_pipe[k]),
            .o_valid (w_vld_pipe[k+1]),
            .o_data  (w_data_pipe[k+1])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_bubbles <= '0;
        else if (!stall && !w_vld_pipe[DEPTH] && r_bubbles != 16'hFFFF)
            r_bubbles <= r_bubbles + 16'd1;
    end

    assign {ALU_out, SH_out, C_out, T_out, DATA_ADDR_out, M_out} = w_data_pipe[DEPTH];
    assign out_valid   = w_vld_pipe[DEPTH];
    assign stage_valid = w_vld_pipe[DEPTH:1];
    assign bubbles     = r_bubbles;

endmodule

// File: tb/tb_micro_pipeline.sv
// Directed bench: stimulus pushes accepted words into a queue, a monitor pops
// and compares each new valid output; directed checks cover timing corners.
module tb_micro_pipeline;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = '0;

    logic [3:0]  ALU_out;
    logic [1:0]  SH_out;
    logic [5:0]  C_out;
    logic [6:0]  T_out;
    logic [10:0] DATA_ADDR_out;
    logic [1:0]  M_out;
    logic        out_valid;
    logic [1:0]  stage_valid;
    logic [15:0] bubbles;

    logic        in_valid5 = 1'b0;
    logic [10:0] addr5 = '0;
    logic [3:0]  alu5;
    logic [1:0]  sh5;
    logic [5:0]  c5;
    logic [6:0]  t5;
    logic [10:0] addr5_out;
    logic [1:0]  m5;
    logic        out_valid5;
    logic [4:0]  stage_valid5;
    logic [15:0] bubbles5;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    micro_pipeline #(.DEPTH(2)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .ALU_in(in_word[31:28]), .SH_in(in_word[27:26]), .C_in(in_word[25:20]),
        .T_in(in_word[19:13]), .DATA_ADDR_in(in_word[12:2]), .M_in(in_word[1:0]),
        .ALU_out(ALU_out), .SH_out(SH_out), .C_out(C_out), .T_out(T_out),
        .DATA_ADDR_out(DATA_ADDR_out), .M_out(M_out),
        .out_valid(out_valid), .stage_valid(stage_valid), .bubbles(bubbles)
    );

    micro_pipeline #(.DEPTH(5)) dut5 (
        .clock(clock), .reset(reset), .stall(1'b0), .flush(1'b0), .in_valid(in_valid5),
        .ALU_in(4'h0), .SH_in(2'h0), .C_in(6'h0), .T_in(7'h0), .DATA_ADDR_in(addr5), .M_in(2'h0),
        .ALU_out(alu5), .SH_out(sh5), .C_out(c5), .T_out(t5),
        .DATA_ADDR_out(addr5_out), .M_out(m5),
        .out_valid(out_valid5), .stage_valid(stage_valid5), .bubbles(bubbles5)
    );

    function automatic logic [31:0] mk(input logic [3:0] a, input logic [1:0] s, input logic [5:0] c,
                                       input logic [6:0] t, input logic [10:0] d, input logic [1:0] m);
        return {a, s, c, t, d, m};
    endfunction

    function automatic logic [31:0] out_word();
        return {ALU_out, SH_out, C_out, T_out, DATA_ADDR_out, M_out};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; the model records only accepted words.
    task automatic step(input logic v, input logic [31:0] w, input logic st, input logic fl);
        in_valid = v;
        in_word  = w;
        stall    = st;
        flush    = fl;
        if (fl)           exp_q.delete();
        else if (!st && v) exp_q.push_back(w);
        @(negedge clock);
    endtask

    // Monitor: a new output word appears only after an edge that advanced the pipe.
    initial begin
        logic adv;
        forever begin
            @(posedge clock);
            adv = !stall && !flush && !reset;
            #1;
            if (out_valid && adv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_word(), 32'h0);
                    if (out_word() == 32'h0) begin
                        miscompares++;
                        $display("FAIL unexpected_out: got valid word, expected none");
                    end
                end else begin
                    check("sb_word", out_word(), exp_q.pop_front());
                end
            end else if (!out_valid) begin
                check("bubble_zero", out_word(), 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] held;
        @(negedge clock);
        check("reset_valid", {30'h0, stage_valid}, 32'h0);
        check("reset_bubbles", {16'h0, bubbles}, 32'h0);
        check("reset_word", out_word(), 32'h0);
        reset = 1'b0;

        // Ten idle cycles count as bubbles; a stalled one does not.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        check("bubbles_10", {16'h0, bubbles}, 32'd10);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bubbles_stall", {16'h0, bubbles}, 32'd10);

        // Two-cycle latency for ALU=A.
        step(1'b1, mk(4'hA, 2'h0, 6'h0, 7'h0, 11'h0, 2'h0), 1'b0, 1'b0);
        check("lat_sv1", {30'h0, stage_valid}, 32'b01);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("lat_sv2", {30'h0, stage_valid}, 32'b10);
        check("lat_alu", {28'h0, ALU_out}, 32'hA);

        // Stall 3 cycles with two valid words; junk inputs are ignored.
        step(1'b1, mk(4'h1, 2'h1, 6'h2A, 7'h11, 11'h123, 2'h3), 1'b0, 1'b0);
        step(1'b1, mk(4'h5, 2'h2, 6'h03, 7'h7F, 11'h456, 2'h1), 1'b0, 1'b0);
        held = out_word();
        check("pre_stall_word", held, mk(4'h1, 2'h1, 6'h2A, 7'h11, 11'h123, 2'h3));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
            check("stall_hold", out_word(), mk(4'h1, 2'h1, 6'h2A, 7'h11, 11'h123, 2'h3));
            check("stall_sv", {30'h0, stage_valid}, 32'b11);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("adv_word", out_word(), mk(4'h5, 2'h2, 6'h03, 7'h7F, 11'h456, 2'h1));
        check("adv_sv", {30'h0, stage_valid}, 32'b10);

        // Flush with stall in the same cycle clears both full stages.
        step(1'b1, mk(4'h2, 2'h0, 6'h01, 7'h01, 11'h001, 2'h0), 1'b0, 1'b0);
        step(1'b1, mk(4'h3, 2'h0, 6'h02, 7'h02, 11'h002, 2'h0), 1'b0, 1'b0);
        check("preflush_sv", {30'h0, stage_valid}, 32'b11);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("flush_sv", {30'h0, stage_valid}, 32'b00);
        check("flush_word", out_word(), 32'h0);

        // Accept right after flush: out_valid exactly two edges later.
        step(1'b1, mk(4'hC, 2'h3, 6'h15, 7'h40, 11'h7FF, 2'h2), 1'b0, 1'b0);
        check("pf_ov1", {31'h0, out_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("pf_ov2", {31'h0, out_valid}, 32'h1);
        check("pf_c", {26'h0, C_out}, 32'h15);

        // Asynchronous reset between edges while C_out=15.
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("areset_c", {26'h0, C_out}, 32'h0);
        check("areset_ov", {31'h0, out_valid}, 32'h0);
        check("areset_bub", {16'h0, bubbles}, 32'h0);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post_reset_sv", {30'h0, stage_valid}, 32'b00);
        check("post_reset_bub", {16'h0, bubbles}, 32'd1);

        // Back-to-back stream after reset for the scoreboard.
        step(1'b1, mk(4'h9, 2'h1, 6'h3F, 7'h00, 11'h400, 2'h1), 1'b0, 1'b0);
        step(1'b1, mk(4'hF, 2'h3, 6'h3F, 7'h7F, 11'h7FF, 2'h3), 1'b0, 1'b0);
        step(1'b1, mk(4'h6, 2'h2, 6'h10, 7'h2A, 11'h0AA, 2'h0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        check("sb_drained", exp_q.size(), 32'd0);

        // DEPTH=5 carries full-width DATA_ADDR in exactly five edges.
        in_valid5 = 1'b1;
        addr5     = 11'h7FF;
        @(negedge clock);
        in_valid5 = 1'b0;
        addr5     = '0;
        for (int k = 2; k <= 5; k++) begin
            check("d5_ov_early", {31'h0, out_valid5}, 32'h0);
            @(negedge clock);
        end
        check("d5_ov", {31'h0, out_valid5}, 32'h1);
        check("d5_addr", {21'h0, addr5_out}, 32'h7FF);
        @(negedge clock);
        check("d5_ov_after", {31'h0, out_valid5}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
